integral_sequencer: RTL and testbench
=====================================

# integral_sequencer

Sequences trapezoidal integration over a stream of `N`-bit floating-point samples. The block owns no arithmetic. It drives one external floating-point adder through a request/acknowledge handshake and holds the running accumulator. It sits between the sample source and the shared adder, controlled by `start_integration`. It replaces free-running accumulation with a counted, abortable integration run.

## Interface
- `N`, 16: sample, operand and result width; equals the project-wide `` `N ``.
- `NUM_SAMPLES`, 8: samples per run, ≥1.
- `ZERO`, 0: floating-point encoding of +0.0; accumulator init value.
- `CW`, $clog2(NUM_SAMPLES+1): width of `sample_count`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `resetb` in 1: asynchronous, active-low reset.
- `start_integration` in 1: level input; a run starts on its 0→1 transition.
- `abort` in 1: cancels the current run.
- `sample_data` in N: input sample.
- `sample_valid` in 1: `sample_data` is valid.
- `sample_ready` out 1: the block accepts a sample this cycle.
- `add_req` out 1: adder request.
- `add_a`, `add_b` out N: adder operands.
- `add_ack` in 1: adder result valid on `add_sum`.
- `add_sum` in N: adder result.
- `integral_result` out N: accumulated result. Holds its value until the next run starts.
- `result_valid` out 1: one-cycle pulse when a run completes.
- `busy` out 1: high in every state except IDLE.
- `sample_count` out CW: number of samples accepted in the current run.

## Operation
- Result definition: Σ(x[k-1]+x[k]) for k=1..NUM_SAMPLES-1. The 0.5·dt scaling is applied downstream.
- States: IDLE, WAIT_FIRST, WAIT_SAMPLE, ADD_PAIR, ADD_ACC, DONE.
- IDLE: on a rising edge of `start_integration`:
  - clear acc to ZERO and `sample_count` to 0;
  - go to WAIT_FIRST.
- WAIT_FIRST: `sample_ready`=1. On `sample_valid`:
  - store x_prev=`sample_data` and increment `sample_count`;
  - if NUM_SAMPLES==1, go to DONE; otherwise go to WAIT_SAMPLE.
- WAIT_SAMPLE: `sample_ready`=1. On `sample_valid`:
  - store x_cur and increment `sample_count`;
  - go to ADD_PAIR.
- ADD_PAIR: `add_req`=1, `add_a`=x_prev, `add_b`=x_cur. On `add_ack`:
  - t=`add_sum` and x_prev=x_cur;
  - go to ADD_ACC.
- ADD_ACC: `add_req`=1, `add_a`=acc, `add_b`=t. On `add_ack`:
  - acc=`add_sum`;
  - if `sample_count`==NUM_SAMPLES, go to DONE; otherwise go to WAIT_SAMPLE.
- DONE: `integral_result`=acc and `result_valid`=1 for exactly one cycle, then go to IDLE.
- `sample_ready` is 0 in all other states. A sample is accepted only when `sample_valid`&`sample_ready`.
- `start_integration` edges while `busy` are ignored. The edge detector is still updated every cycle.
- `abort` from WAIT_FIRST or WAIT_SAMPLE: go to IDLE on the next edge.
- `abort` from ADD_PAIR or ADD_ACC: `add_req` stays high until `add_ack`, the sum is discarded, then go to IDLE. Abort is latched in a sticky flag until used.
- Aborted runs: no `result_valid`, and `integral_result` is unchanged.
- `abort` in DONE or IDLE has no effect.

## Timing
- Reset values (async assert, sync-free deassert):
  - state IDLE; acc, x_prev, x_cur, t = ZERO;
  - `integral_result`=ZERO and `sample_count`=0;
  - `sample_ready`, `add_req`, `result_valid`, `busy` = 0;
  - start-edge register = 0, so `start_integration` already high at reset release does not start a run.
- Reset mid-run: return to IDLE immediately. Any outstanding adder ack after reset is ignored.
- Start latency: a rising `start_integration` sampled at edge E moves to WAIT_FIRST at E, so `sample_ready` is 1 the following cycle.
- Handshake rules:
  - `add_req` is a state decode;
  - `add_a`/`add_b` are stable while `add_req`=1;
  - `add_ack` may arrive in the first req cycle;
  - `add_ack` with `add_req`=0 is ignored.
- Adder latency L: `result_valid` is high in the cycle after the 2·L-th edge following acceptance of the final sample.
- Throughput: one sample per 2·L+1 cycles when the adder is the bottleneck.
- `sample_count` saturates at NUM_SAMPLES.

## Test plan
- NUM_SAMPLES=5, L=2, samples 2,4,6,8,10 → adds (2,4),(0,6),(4,6),(6,10),(6,8),(16,14),(8,10),(30,18); `integral_result`=48 with a single `result_valid` pulse, 4 cycles after the final sample is accepted.
- `start_integration` held high through reset release, samples offered → no run starts and `sample_ready` stays 0. Drop then raise start → run begins.
- `abort` asserted in ADD_ACC of pair 2 with L=3 → `add_req` held until ack, then IDLE. No `result_valid`; `integral_result` keeps the prior 48.
- NUM_SAMPLES=1, sample 7 → `result_valid` with `integral_result`=ZERO, `add_req` never asserted.
- `sample_valid` stuck high during ADD_* states with L=4 → `sample_ready`=0, no samples lost or duplicated. Result for 1,1,1,1,1 = 8.
- `resetb` pulsed low in ADD_PAIR → all outputs at reset values asynchronously. A late `add_ack` is ignored, and the next run yields the correct sum.

Source files
------------

// File: rtl/integral_sequencer_if.sv
// rtl/integral_sequencer_if.sv - sample, adder and result signals of the integral sequencer
interface integral_sequencer_if #(
   parameter int N  = 16,
   parameter int CW = 4
);
   logic          start_integration;
   logic          abort;
   logic [N-1:0]  sample_data;
   logic          sample_valid;
   logic          sample_ready;
   logic          add_req;
   logic [N-1:0]  add_a;
   logic [N-1:0]  add_b;
   logic          add_ack;
   logic [N-1:0]  add_sum;
   logic [N-1:0]  integral_result;
   logic          result_valid;
   logic          busy;
   logic [CW-1:0] sample_count;

   modport master (
      input  start_integration, abort, sample_data, sample_valid, add_ack, add_sum,
      output sample_ready, add_req, add_a, add_b, integral_result, result_valid, busy, sample_count
   );

   modport slave (
      output start_integration, abort, sample_data, sample_valid, add_ack, add_sum,
      input  sample_ready, add_req, add_a, add_b, integral_result, result_valid, busy, sample_count
   );
endinterface

// File: rtl/integral_sequencer.sv
// rtl/integral_sequencer.sv - trapezoidal integration sequencer driving an external FP adder
module integral_sequencer #(
   parameter int           N           = 16,
   parameter int           NUM_SAMPLES = 8,
   parameter logic [N-1:0] ZERO        = '0,
   parameter int           CW          = $clog2(NUM_SAMPLES + 1)
) (
   input logic                 i_clk,
   input logic                 i_resetb,
   integral_sequencer_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_FIRST, S_WAIT_SAMPLE, S_ADD_PAIR, S_ADD_ACC, S_DONE
   } state_t;

   state_t        r_state;
   logic          r_start_low;
   logic          r_abort_pend;
   logic [N-1:0]  r_acc;
   logic [N-1:0]  r_x_prev;
   logic [N-1:0]  r_x_cur;
   logic [N-1:0]  r_t;
   logic [CW-1:0] r_count;
   logic          r_sample_ready;
   logic          r_add_req;
   logic [N-1:0]  r_add_a;
   logic [N-1:0]  r_add_b;
   logic [N-1:0]  r_result;
   logic          r_result_valid;
   logic          r_busy;

   // r_start_low resets to 0, so a start already high at reset release is not an edge
   logic          w_start_rise;
   logic          w_abort_any;
   logic [CW-1:0] w_count_inc;

   assign w_start_rise = bus.start_integration & r_start_low;
   assign w_abort_any  = bus.abort | r_abort_pend;
   assign w_count_inc  = (r_count == CW'(NUM_SAMPLES)) ? r_count : r_count + CW'(1);

   always_ff @(posedge i_clk or negedge i_resetb) begin
      if (!i_resetb) begin
         r_state        <= S_IDLE;
         r_start_low    <= 1'b0;
         r_abort_pend   <= 1'b0;
         r_acc          <= ZERO;
         r_x_prev       <= ZERO;
         r_x_cur        <= ZERO;
         r_t            <= ZERO;
         r_count        <= '0;
         r_sample_ready <= 1'b0;
         r_add_req      <= 1'b0;
         r_add_a        <= ZERO;
         r_add_b        <= ZERO;
         r_result       <= ZERO;
         r_result_valid <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         r_start_low    <= ~bus.start_integration;
         r_result_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start_rise) begin
                  r_acc          <= ZERO;
                  r_count        <= '0;
                  r_abort_pend   <= 1'b0;
                  r_state        <= S_WAIT_FIRST;
                  r_sample_ready <= 1'b1;
                  r_busy         <= 1'b1;
               end
            end
            S_WAIT_FIRST: begin
               if (bus.abort) begin
                  r_state        <= S_IDLE;
                  r_sample_ready <= 1'b0;
                  r_busy         <= 1'b0;
               end else if (bus.sample_valid) begin
                  r_x_prev <= bus.sample_data;
                  r_count  <= w_count_inc;
                  if (NUM_SAMPLES == 1) begin
                     r_state        <= S_DONE;
                     r_sample_ready <= 1'b0;
                     r_result       <= r_acc;
                     r_result_valid <= 1'b1;
                  end else begin
                     r_state <= S_WAIT_SAMPLE;
                  end
               end
            end
            S_WAIT_SAMPLE: begin
               if (bus.abort) begin
                  r_state        <= S_IDLE;
                  r_sample_ready <= 1'b0;
                  r_busy         <= 1'b0;
               end else if (bus.sample_valid) begin
                  r_x_cur        <= bus.sample_data;
                  r_count        <= w_count_inc;
                  r_state        <= S_ADD_PAIR;
                  r_sample_ready <= 1'b0;
                  r_add_req      <= 1'b1;
                  r_add_a        <= r_x_prev;
                  r_add_b        <= bus.sample_data;
               end
            end
            S_ADD_PAIR, S_ADD_ACC: begin
               // an abort during an add waits for the ack so the adder is never left mid-request
               if (bus.abort) r_abort_pend <= 1'b1;
               if (bus.add_ack) begin
                  if (w_abort_any) begin
                     r_state      <= S_IDLE;
                     r_add_req    <= 1'b0;
                     r_busy       <= 1'b0;
                     r_abort_pend <= 1'b0;
                  end else if (r_state == S_ADD_PAIR) begin
                     r_t      <= bus.add_sum;
                     r_x_prev <= r_x_cur;
                     r_state  <= S_ADD_ACC;
                     r_add_a  <= r_acc;
                     r_add_b  <= bus.add_sum;
                  end else begin
                     r_acc     <= bus.add_sum;
                     r_add_req <= 1'b0;
                     if (r_count == CW'(NUM_SAMPLES)) begin
                        r_state        <= S_DONE;
                        r_result       <= bus.add_sum;
                        r_result_valid <= 1'b1;
                     end else begin
                        r_state        <= S_WAIT_SAMPLE;
                        r_sample_ready <= 1'b1;
                     end
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state        <= S_IDLE;
               r_sample_ready <= 1'b0;
               r_add_req      <= 1'b0;
               r_busy         <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sample_ready    = r_sample_ready;
   assign bus.add_req         = r_add_req;
   assign bus.add_a           = r_add_a;
   assign bus.add_b           = r_add_b;
   assign bus.integral_result = r_result;
   assign bus.result_valid    = r_result_valid;
   assign bus.busy            = r_busy;
   assign bus.sample_count    = r_count;
endmodule

// File: tb/tb_integral_sequencer.sv
// tb/tb_integral_sequencer.sv - directed bench for integral_sequencer with a half-precision adder model
module tb_integral_sequencer;
   logic clk;
   logic resetb;

   integral_sequencer_if #(.N(16), .CW(3)) bus5 ();
   integral_sequencer_if #(.N(16), .CW(1)) bus1 ();

   integral_sequencer #(.N(16), .NUM_SAMPLES(5), .ZERO(16'h0000), .CW(3)) dut5 (
      .i_clk(clk), .i_resetb(resetb), .bus(bus5)
   );
   integral_sequencer #(.N(16), .NUM_SAMPLES(1), .ZERO(16'h0000), .CW(1)) dut1 (
      .i_clk(clk), .i_resetb(resetb), .bus(bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0, accepts = 0, rv_count = 0, rv_cyc = 0, rv1_count = 0, nreq = 0;
   int lat = 2, acnt = 0, last_acc_cyc = 0;
   logic model_ack = 1'b0, stray_ack = 1'b0, ready_seen = 1'b0, req1_seen = 1'b0;
   logic [15:0] op_a [0:31];
   logic [15:0] op_b [0:31];

   function automatic real h2r(input logic [15:0] h);
      int  e;
      real m;
      real r;
      e = int'(h[14:10]);
      m = real'(h[9:0]) / 1024.0;
      if (e == 0) r = m * (2.0 ** (-14));
      else        r = (1.0 + m) * (2.0 ** (e - 15));
      return h[15] ? -r : r;
   endfunction

   function automatic logic [15:0] r2h(input real r);
      int  e;
      real m;
      if (r == 0.0) return 16'h0000;
      e = 0;
      m = r;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0)  begin m = m * 2.0; e--; end
      return {1'b0, 5'(e + 15), 10'($rtoi((m - 1.0) * 1024.0 + 0.5))};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // adder model (latency lat, ack in the lat-th request cycle) plus output monitor
   initial begin
      bus5.add_ack = 1'b0;
      bus5.add_sum = 16'h0000;
      forever begin
         @(posedge clk);
         cyc++;
         if (bus5.sample_valid && bus5.sample_ready) accepts++;
         #1;
         if (bus5.result_valid) begin rv_count++; rv_cyc = cyc; end
         if (bus5.sample_ready) ready_seen = 1'b1;
         if (bus1.add_req) req1_seen = 1'b1;
         if (bus1.result_valid) rv1_count++;
         if (!bus5.add_req || !resetb) begin
            acnt = 0;
            model_ack = 1'b0;
         end else begin
            if (model_ack) acnt = 0;
            acnt++;
            if (acnt == 1 && nreq < 32) begin
               op_a[nreq] = bus5.add_a;
               op_b[nreq] = bus5.add_b;
               nreq++;
            end
            model_ack = (acnt == lat);
            bus5.add_sum = r2h(h2r(bus5.add_a) + h2r(bus5.add_b));
         end
         if (stray_ack) bus5.add_sum = 16'h7777;
         bus5.add_ack = model_ack | stray_ack;
      end
   end

   task automatic send(input logic [15:0] d);
      int t;
      t = 0;
      bus5.sample_data  = d;
      bus5.sample_valid = 1'b1;
      while (!bus5.sample_ready && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) begin
         chk("send_timeout", 1, 0);
      end else begin
         @(posedge clk);
         #1;
         last_acc_cyc = cyc;
      end
      bus5.sample_valid = 1'b0;
   endtask

   task automatic wait_rv(input int base, input int bound);
      int t;
      t = 0;
      while (rv_count == base && t < bound) begin @(negedge clk); t++; end
      chk("rv_wait", 32'(rv_count != base), 1);
   endtask

   task automatic restart();
      bus5.start_integration = 1'b0;
      @(negedge clk);
      bus5.start_integration = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic [15:0] ea [0:7];
      logic [15:0] eb [0:7];
      int base_req, base_rv, base_acc, t;
      logic held_ok;

      ea = '{16'h4000, 16'h0000, 16'h4400, 16'h4600, 16'h4600, 16'h4C00, 16'h4800, 16'h4F80};
      eb = '{16'h4400, 16'h4600, 16'h4600, 16'h4900, 16'h4800, 16'h4B00, 16'h4900, 16'h4C80};
      resetb = 1'b0;
      bus5.start_integration = 1'b1;
      bus5.abort = 1'b0;
      bus5.sample_valid = 1'b0;
      bus5.sample_data = 16'h0000;
      bus1.start_integration = 1'b0;
      bus1.abort = 1'b0;
      bus1.sample_valid = 1'b0;
      bus1.sample_data = 16'h0000;
      bus1.add_ack = 1'b0;
      bus1.add_sum = 16'h0000;
      repeat (2) @(negedge clk);
      chk("rst_result", bus5.integral_result, 16'h0000);
      chk("rst_count", bus5.sample_count, 0);
      chk("rst_ready", bus5.sample_ready, 0);
      chk("rst_req", bus5.add_req, 0);
      chk("rst_rv", bus5.result_valid, 0);
      chk("rst_busy", bus5.busy, 0);

      // start held high through reset release must not begin a run
      resetb = 1'b1;
      bus5.sample_valid = 1'b1;
      bus5.sample_data = 16'h4000;
      repeat (8) @(negedge clk);
      chk("held_start_ready", ready_seen, 0);
      chk("held_start_busy", bus5.busy, 0);
      bus5.sample_valid = 1'b0;

      // run 1: L=2, samples 2,4,6,8,10 -> 48
      base_req = nreq;
      base_rv = rv_count;
      restart();
      chk("start_ready", bus5.sample_ready, 1);
      chk("start_busy", bus5.busy, 1);
      chk("start_count", bus5.sample_count, 0);
      send(16'h4000); send(16'h4400); send(16'h4600); send(16'h4800); send(16'h4900);
      wait_rv(base_rv, 50);
      chk("run1_result", bus5.integral_result, 16'h5200);
      chk("run1_latency", rv_cyc - last_acc_cyc, 4);
      repeat (3) @(negedge clk);
      chk("run1_pulses", rv_count - base_rv, 1);
      chk("run1_count", bus5.sample_count, 5);
      chk("run1_nreq", nreq - base_req, 8);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("run1_add%0d_a", i), op_a[base_req + i], ea[i]);
         chk($sformatf("run1_add%0d_b", i), op_b[base_req + i], eb[i]);
      end

      // run 2: L=3, abort in ADD_ACC of pair 2
      lat = 3;
      base_req = nreq;
      base_rv = rv_count;
      restart();
      send(16'h4000); send(16'h4400); send(16'h4600);
      t = 0;
      while (nreq < base_req + 4 && t < 50) begin @(negedge clk); t++; end
      chk("abort_reach_acc2", nreq - base_req, 4);
      bus5.abort = 1'b1;
      @(negedge clk);
      bus5.abort = 1'b0;
      held_ok = 1'b1;
      t = 0;
      while (bus5.busy && t < 20) begin
         if (!bus5.add_req) held_ok = 1'b0;
         @(negedge clk);
         t++;
      end
      chk("abort_idle", bus5.busy, 0);
      chk("abort_req_held", held_ok, 1);
      chk("abort_req_low", bus5.add_req, 0);
      chk("abort_no_new_req", nreq - base_req, 4);
      repeat (3) @(negedge clk);
      chk("abort_no_rv", rv_count - base_rv, 0);
      chk("abort_result_kept", bus5.integral_result, 16'h5200);

      // run 3: L=4, sample_valid stuck high, 1,1,1,1,1 -> 8
      lat = 4;
      base_rv = rv_count;
      base_acc = accepts;
      bus5.start_integration = 1'b0;
      @(negedge clk);
      bus5.sample_data = 16'h3C00;
      bus5.sample_valid = 1'b1;
      bus5.start_integration = 1'b1;
      wait_rv(base_rv, 300);
      chk("stuck_result", bus5.integral_result, 16'h4800);
      @(negedge clk);
      bus5.sample_valid = 1'b0;
      chk("stuck_accepts", accepts - base_acc, 5);
      chk("stuck_count", bus5.sample_count, 5);

      // run 4: reset pulse in ADD_PAIR, stray ack, then a clean run with L=1
      restart();
      send(16'h4000); send(16'h4400);
      @(negedge clk);
      chk("rstmid_in_pair", bus5.add_req, 1);
      #2 resetb = 1'b0;
      #1;
      chk("rstmid_req", bus5.add_req, 0);
      chk("rstmid_busy", bus5.busy, 0);
      chk("rstmid_ready", bus5.sample_ready, 0);
      chk("rstmid_count", bus5.sample_count, 0);
      chk("rstmid_result", bus5.integral_result, 16'h0000);
      @(negedge clk);
      resetb = 1'b1;
      stray_ack = 1'b1;
      repeat (2) @(negedge clk);
      stray_ack = 1'b0;
      @(negedge clk);
      chk("stray_busy", bus5.busy, 0);
      chk("stray_req", bus5.add_req, 0);
      chk("stray_result", bus5.integral_result, 16'h0000);
      lat = 1;
      base_rv = rv_count;
      restart();
      send(16'h4000); send(16'h4400); send(16'h4600); send(16'h4800); send(16'h4900);
      wait_rv(base_rv, 50);
      chk("rerun_result", bus5.integral_result, 16'h5200);

      // NUM_SAMPLES=1 instance: single sample 7 -> ZERO, no adder use
      bus1.start_integration = 1'b1;
      @(negedge clk);
      bus1.sample_data = 16'h4700;
      bus1.sample_valid = 1'b1;
      t = 0;
      while (!bus1.sample_ready && t < 20) begin @(negedge clk); t++; end
      chk("n1_ready", bus1.sample_ready, 1);
      @(negedge clk);
      bus1.sample_valid = 1'b0;
      t = 0;
      while (rv1_count == 0 && t < 20) begin @(negedge clk); t++; end
      chk("n1_rv", rv1_count, 1);
      chk("n1_result", bus1.integral_result, 16'h0000);
      chk("n1_count", bus1.sample_count, 1);
      chk("n1_no_req", req1_seen, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
